// File: rtl/dsp_mac_sequencer.sv
// Sequences (a, b) operand frames into a DSP48A1 slice as a sum of products and returns the result.
// Optional rounding offset on the first product: define DSP_MAC_ROUND_EN.
module dsp_mac_sequencer #(
    parameter int unsigned PIPE_LAT  = 3,
    parameter int unsigned OPM_DLY   = 1,
    parameter int unsigned MAX_LEN   = 1024,
    parameter int unsigned ROUND_BIT = 16
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    input  logic        s_last,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [47:0] dsp_c,
    output logic [7:0]  dsp_opmode,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_result,
    output logic        m_carry,
    output logic        m_err,
    output logic [15:0] m_len
);

`ifdef DSP_MAC_ROUND_EN
    localparam bit RoundEn = 1'b1;
`else
    localparam bit RoundEn = 1'b0;
`endif

    localparam logic [47:0] RoundC    = 48'h1 << (ROUND_BIT - 1);
    localparam logic [7:0]  OpmHold   = 8'h08;
    localparam logic [7:0]  OpmAcc    = 8'h09;
    localparam logic [7:0]  OpmFirst  = RoundEn ? 8'h0D : 8'h01;
    localparam logic [15:0] MaxLen    = 16'(MAX_LEN);
    localparam logic [7:0]  DrainLoad = 8'(PIPE_LAT);

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  drain_q, drain_d;
    logic        trunc_q, trunc_d;
    logic [7:0]  opm_slot;
    logic        accept;
    logic        capture;
    logic        pop;

    // Stage 0 holds the slot chosen at the accepting edge; the last stage drives the slice.
    logic [OPM_DLY:0][7:0] opm_q;

    assign s_ready    = (state_q == StIdle) || (state_q == StAccum);
    assign accept     = s_valid && s_ready;
    assign dsp_opmode = opm_q[OPM_DLY];
    assign dsp_c      = RoundEn ? RoundC : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        trunc_d  = trunc_q;
        opm_slot = OpmHold;
        capture  = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    opm_slot = OpmFirst;
                    cnt_d    = 16'd1;
                    trunc_d  = 1'b0;
                    if (s_last) begin
                        state_d = StDrain;
                        drain_d = DrainLoad;
                    end else begin
                        state_d = StAccum;
                    end
                end
            end
            StAccum: begin
                if (s_valid) begin
                    opm_slot = OpmAcc;
                    cnt_d    = cnt_q + 16'd1;
                    if (s_last || (cnt_d == MaxLen)) begin
                        state_d = StDrain;
                        drain_d = DrainLoad;
                        trunc_d = !s_last;
                    end
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    capture = 1'b1;
                    state_d = StHold;
                end else begin
                    drain_d = drain_q - 8'd1;
                end
            end
            StHold: begin
                if (m_valid && m_ready) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            drain_q  <= '0;
            trunc_q  <= 1'b0;
            opm_q    <= {(OPM_DLY + 1){OpmHold}};
            dsp_a    <= '0;
            dsp_b    <= '0;
            m_valid  <= 1'b0;
            m_result <= '0;
            m_carry  <= 1'b0;
            m_err    <= 1'b0;
            m_len    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            trunc_q  <= trunc_d;
            dsp_a    <= accept ? s_a : '0;
            dsp_b    <= accept ? s_b : '0;
            opm_q[0] <= opm_slot;
            for (int unsigned i = 1; i <= OPM_DLY; i++) begin
                opm_q[i] <= opm_q[i-1];
            end
            if (capture) begin
                m_valid  <= 1'b1;
                m_result <= dsp_p;
                m_carry  <= dsp_carryout;
                m_err    <= trunc_q;
                m_len    <= cnt_q;
            end else if (pop) begin
                m_valid <= 1'b0;
                m_err   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Upstream controller for one DSP48A1 slice in its default pipeline configuration (A1REG/B1REG/MREG/PREG/OPMODEREG = 1, A0REG/B0REG = 0, CARRYINSEL = "OPMODE5").
- Accepts a valid/ready stream of (a, b) operand beats grouped into frames by s_last. Drives the slice's A, B and OPMODE so that each frame is accumulated as a sum of products.
- Captures the slice's P and CARRYOUT for the final beat and presents the frame result on a valid/ready output port.

Parameters:
- PIPE_LAT, 3, slice latency in CLK edges from a dsp_a/dsp_b update to the corresponding dsp_p being valid.
- OPM_DLY, 1, edges by which dsp_opmode lags dsp_a/dsp_b. Must equal PIPE_LAT-2.
- MAX_LEN, 1024, maximum beats per frame (2..65535).
- ROUND_BIT, 16, rounding position; used only with ROUND_EN.

Ports:
- CLK  in  1  clock, rising edge.
- RSTB  in  1  reset, asynchronous, active-high.
- s_valid  in  1  operand beat valid.
- s_ready  out  1  sequencer can accept a beat.
- s_a  in  18  multiplier operand A (unsigned).
- s_b  in  18  multiplier operand B (unsigned).
- s_last  in  1  final beat of the frame.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_c  out  48  to slice C.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_p  in  48  from slice P.
- dsp_carryout  in  1  from slice CARRYOUT.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_result  out  48  accumulated sum.
- m_carry  out  1  slice CARRYOUT captured with the result.
- m_err  out  1  frame was truncated at MAX_LEN.
- m_len  out  16  number of beats in the frame.

Behaviour:
- Reset values: all outputs 0 except s_ready = 1 and dsp_opmode = 8'h08. State = IDLE, counters = 0.
- A beat is accepted when s_valid && s_ready at a rising edge (edge k).
  - At edge k: dsp_a <= s_a, dsp_b <= s_b.
  - At edge k+OPM_DLY: dsp_opmode is updated for that beat.
- In any cycle with no accepted beat: dsp_a/dsp_b <= 0, and the delayed opmode slot is 8'h08 (X=0, Z=P, hold P).
- Opmode encoding:
  - First beat of a frame: 8'h01 (X=M, Z=0).
  - Later beats: 8'h09 (X=M, Z=P).
  - Bits [7:4] are always 0: add, carry-in 0, pre-adder bypassed.
- Opmode values travel through an OPM_DLY-deep shift register. No opmode value is ever dropped.
- States:
  - IDLE: s_ready = 1. Accepted beat gets the first-beat opmode and sets beat count = 1. If s_last is set go to DRAIN, otherwise go to ACCUM.
  - ACCUM: s_ready = 1. Each accepted beat increments the beat count. The beat with s_last, or beat number MAX_LEN, goes to DRAIN. On truncation m_err is latched to 1.
  - DRAIN: s_ready = 0. Down-counter loaded with PIPE_LAT. At the edge where the counter reaches 0 (edge k+PIPE_LAT+1, k = last-beat edge): m_result <= dsp_p, m_carry <= dsp_carryout, m_len <= beat count, m_valid <= 1. Then go to HOLD.
  - HOLD: s_ready = 0, outputs held stable. On m_valid && m_ready: m_valid <= 0, m_err <= 0, go to IDLE. One bubble cycle occurs before the next frame is accepted.
- Gaps within a frame (s_valid = 0 in ACCUM) insert hold opmodes. The result is unaffected.
- m_len is 16 bits and never wraps, because MAX_LEN ≤ 65535.
- Reset mid-frame: all state is cleared immediately and the partial frame is discarded with no m_valid. The first beat after reset uses opmode 8'h01, so the stale P value is ignored.

Optional Feature:
- Macro: DSP_MAC_ROUND_EN.
- Defined: dsp_c = 48'h1 << (ROUND_BIT-1), constant. First-beat opmode becomes 8'h0D (X=M, Z=C), so every result includes the rounding offset.
- Undefined: dsp_c = 0, and the first-beat opmode is 8'h01.

Test Plan:
- Frame (1,2),(3,4),(5,6),(7,8) back-to-back, m_ready = 1 -> m_result = 100, m_len = 4, m_err = 0. m_valid is asserted at edge last+PIPE_LAT+1, for 1 cycle.
- Single-beat frame (18'h3FFFF, 18'h3FFFF) with s_last -> m_result = 48'h000FFFF80001, m_carry = 0. s_ready is low from the accepting edge until the cycle after the handshake.
- Frame (2,3), gap of 5 idle cycles, (4,5, last) -> m_result = 26. dsp_opmode shows 8'h08 during the gap.
- m_ready held low 10 cycles after m_valid -> m_result stable, s_ready = 0, and the new s_valid beat is not accepted. After the handshake, the next frame's first beat is accepted and gets opmode 8'h01.
- MAX_LEN = 4, six beats of (1,1) with no s_last -> first result m_result = 4, m_err = 1, m_len = 4. The remaining two beats form a new frame: m_result = 2 when the second carries s_last.
- RSTB pulsed mid-ACCUM after 2 beats -> no m_valid. The next frame (3,3, last) gives m_result = 9; with DSP_MAC_ROUND_EN defined it gives 9 + 32768.
